// File: rtl/mips_multicycle_control.sv
// Multi-cycle control FSM for the mini-MIPS core: sequences fetch, decode,
// execute, memory and write-back and owns the unified memory handshake.
module mips_multicycle_control #(
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [1:0] instr_type,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_imm,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       halted,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [2:0] C_R   = 3'd0;
  localparam logic [2:0] C_JR  = 3'd1;
  localparam logic [2:0] C_IMM = 3'd2;
  localparam logic [2:0] C_LW  = 3'd3;
  localparam logic [2:0] C_SW  = 3'd4;
  localparam logic [2:0] C_BR  = 3'd5;
  localparam logic [2:0] C_J   = 3'd6;
  localparam logic [2:0] C_JAL = 3'd7;

  logic [2:0] state_q, state_d;
  logic [2:0] cls_q, cls_d;

  // The instruction class is fully determined by opcode/funct; the decoder's
  // type field is accepted for interface compatibility but not needed here.
  logic unused_type;
  assign unused_type = ^instr_type;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h12, 6'h13, 6'h14, 6'h15,
      6'h16, 6'h17, 6'h23, 6'h2B: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] op_class(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:        op_class = (fn == 6'h08) ? C_JR : C_R;
      6'h02:        op_class = C_J;
      6'h03:        op_class = C_JAL;
      6'h04, 6'h05: op_class = C_BR;
      6'h23:        op_class = C_LW;
      6'h2B:        op_class = C_SW;
      default:      op_class = C_IMM;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'd0;
    wb_sel      = 2'd0;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = op_class(opcode, funct);
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (!op_legal(opcode)) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R:   state_d = S_WB;
          C_IMM: begin alu_src_imm = 1'b1; state_d = S_WB;  end
          C_LW,
          C_SW:  begin alu_src_imm = 1'b1; state_d = S_MEM; end
          C_JR:  begin pc_write = 1'b1; pc_src = 2'd3; state_d = S_FETCH; end
          C_BR:  begin pc_write = branch_taken; pc_src = 2'd1; state_d = S_FETCH; end
          C_J:   begin pc_write = 1'b1; pc_src = 2'd2; state_d = S_FETCH; end
          default: begin
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wb_sel    = 2'd2;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == C_SW);
        if (mem_ready) state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (cls_q == C_R) ? 2'd1 : 2'd0;
        wb_sel    = (cls_q == C_LW) ? 2'd1 : 2'd0;
        state_d   = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_R;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control FSM for the mini-MIPS core. It sequences fetch, decode, execute, memory and write-back around the shared register file, ALU and unified memory port. It consumes the instruction decoder's `opcode`, `funct` and `type` fields and drives the datapath strobes and mux selects. It also owns the memory request/ready handshake for both instruction fetch and data access.

## Interface
Parameters:
- `HALT_OP`, 6'h3F: opcode that stops the core.

Ports:
- `clk`  in  1  single clock; everything on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  leaves IDLE when high.
- `opcode`  in  6  decoder opcode field; valid from DECODE onward.
- `funct`  in  6  decoder funct field.
- `type`  in  2  decoder class: 0 R, 1 I, 2 J, 3 unused.
- `branch_taken`  in  1  datapath compare result; valid in EXEC.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  update the PC.
- `pc_src`  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr).
- `alu_src_imm`  out  1  ALU B operand is `imm`.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = $31.
- `wb_sel`  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `halted`  out  1  high in HALT.
- `state`  out  3  current state, for debug.

## Operation
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6.
- Outputs are combinational from the state register, the latched class registers and `mem_ready`/`branch_taken`. Every output is 0 outside the states listed below.
- **IDLE**: moves to FETCH when `run` = 1.
- **FETCH**:
  - `mem_req` = 1, `mem_we` = 0.
  - Waits while `mem_ready` = 0.
  - In the `mem_ready` cycle: `ir_write` = 1 and `pc_write` = 1 with `pc_src` = 0, then go to DECODE.
- **DECODE**: latches the class from `opcode`/`funct`/`type` into internal registers.
  - `opcode` == `HALT_OP` → HALT.
  - Opcode not in {0, 2, 3, 4, 5, 8, 9, A, C, D, E, F, 12–17, 23, 2B} → `illegal` = 1 for that cycle, then FETCH (executed as NOP).
  - Otherwise → EXEC.
- **EXEC**:
  - R-type (op 0, funct ≠ 08) → WB.
  - jr (op 0, funct 08) → `pc_write` = 1, `pc_src` = 3, then FETCH.
  - Immediate ALU ops (8, 9, A, C, D, E, F, 12–17) → `alu_src_imm` = 1, then WB.
  - lw (23) / sw (2B) → `alu_src_imm` = 1, then MEM.
  - beq (4) / bne (5) → `pc_write` = `branch_taken`, `pc_src` = 1, then FETCH.
  - j (2) → `pc_write` = 1, `pc_src` = 2, then FETCH.
  - jal (3) → same as j, plus `reg_write` = 1, `reg_dst` = 2, `wb_sel` = 2.
- **MEM**:
  - `mem_req` = 1; `mem_we` = 1 for sw.
  - Holds until `mem_ready`.
  - sw → FETCH; lw → WB.
- **WB**: `reg_write` = 1, then FETCH.
  - R-type: `reg_dst` = 1, `wb_sel` = 0.
  - Immediate ALU ops: `reg_dst` = 0, `wb_sel` = 0.
  - lw: `reg_dst` = 0, `wb_sel` = 1.
- **HALT**:
  - `halted` = 1; all strobes 0.
  - Only `rst` leaves HALT; `run` is ignored.
- `run` is sampled only in IDLE. Dropping `run` mid-program has no effect.

## Timing
- Reset:
  - After the edge with `rst` = 1: state = IDLE, latched class cleared, all outputs 0.
  - `rst` overrides every transition, including mid-FETCH or mid-MEM with `mem_req` high. `mem_req` is 0 from that edge on.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first request cycle):
  - R-type and immediate: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j, jal, jr: 3.
  - illegal: 2.
- Handshake:
  - A request completes on the first cycle with `mem_req` && `mem_ready`.
  - `mem_req`/`mem_we` stay stable until then.
  - `mem_ready` is ignored whenever `mem_req` = 0.
  - Each memory wait cycle adds exactly 1 cycle.
- `ir_write` and `pc_write` never assert in the same cycle as `reg_write`, except jal in EXEC.
- A not-taken branch produces no `pc_write` pulse in EXEC. The PC already holds PC+4 from FETCH.

## Test plan
- **Reset and idle**: `rst` for 2 cycles, `run` = 0 for 5 cycles → `state` = 0, all outputs 0. Then `run` = 1 → `state` = 1 and `mem_req` = 1 next cycle.
- **R-type add with 2 fetch wait states**:
  - `mem_ready` low for 2 cycles, then high, with opcode 0, funct 20.
  - Required: `ir_write`/`pc_write` single pulse on cycle 3, then DECODE, EXEC, WB with `reg_write` = 1, `reg_dst` = 1, `wb_sel` = 0, then FETCH.
  - Total 6 cycles.
- **lw then sw, zero-wait**:
  - lw: MEM with `mem_we` = 0, then WB with `wb_sel` = 1, `reg_dst` = 0; 5 cycles.
  - sw: MEM with `mem_req` = 1, `mem_we` = 1, no `reg_write`; 4 cycles.
- **beq taken/not taken, jal, jr**:
  - beq with `branch_taken` = 1 → `pc_write` = 1, `pc_src` = 1. With `branch_taken` = 0 → no EXEC `pc_write`.
  - jal → `pc_src` = 2, `reg_write` = 1, `reg_dst` = 2, `wb_sel` = 2 in one cycle.
  - jr (funct 08) → `pc_src` = 3.
- **Illegal and halt**:
  - Opcode 0x30 → `illegal` pulses for 1 cycle in DECODE, then FETCH.
  - Opcode 0x3F → `halted` = 1 and stays there while `run` toggles; `rst` returns the block to IDLE.
- **Reset mid-MEM**: sw stalled in MEM with `mem_ready` = 0, assert `rst` → next cycle `state` = 0, `mem_req` = 0, `mem_we` = 0.
